reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_file_bypass.sv | 20 ++
 rtl/reg_file.sv | 82 ++++++++
 tb/tb_reg_file.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file, operand-latch stage and control unit.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
package reg_file_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/reg_file_bypass.sv
// Per-read-port forwarding mux: returns in-flight write data when it targets the read index.
// Compiled only when REG_FILE_BYPASS_EN is defined.
`ifdef REG_FILE_BYPASS_EN
module reg_file_bypass #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              fwd_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg,
    input  logic [DATA_W-1:0] stored_data,
    output logic [DATA_W-1:0] read_data
);

    // fwd_en already excludes index 0, so the zero register is never forwarded
    assign read_data = (fwd_en && (read_reg == write_reg)) ? write_data : stored_data;

endmodule
`endif

// File: rtl/reg_file.sv
// Two-read, one-write register file with hardwired zero entry and a committed-write counter.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [15:0]       WrCount
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [15:0]       wr_count;
    logic              wr_en;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    // Case-equality keeps an unknown enable from ever being treated as a write
    assign wr_en = (RegWre === 1'b1) && (WriteReg != ZERO_IDX);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
            wr_count       <= wr_count + 16'd1;
        end
    end

    assign stored1 = (ReadReg1 == ZERO_IDX) ? '0 : regs[ReadReg1];
    assign stored2 = (ReadReg2 == ZERO_IDX) ? '0 : regs[ReadReg2];
    assign WrCount = wr_count;

`ifdef REG_FILE_BYPASS_EN
    logic fwd_en;

    assign fwd_en = wr_en && !Reset;

    reg_file_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass1 (
        .fwd_en      (fwd_en),
        .write_reg   (WriteReg),
        .write_data  (WriteData),
        .read_reg    (ReadReg1),
        .stored_data (stored1),
        .read_data   (ReadData1)
    );

    reg_file_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass2 (
        .fwd_en      (fwd_en),
        .write_reg   (WriteReg),
        .write_data  (WriteData),
        .read_reg    (ReadReg2),
        .stored_data (stored2),
        .read_data   (ReadData2)
    );
`else
    assign ReadData1 = stored1;
    assign ReadData2 = stored2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expected values are hand-computed constants.
// Same-cycle read expectations depend on whether REG_FILE_BYPASS_EN is defined.
module tb_reg_file;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        RegWre;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [15:0] WrCount;

    int compared   = 0;
    int mismatched = 0;

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .RegWre    (RegWre),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .WrCount   (WrCount)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        RegWre    = 1'b1;
        WriteReg  = addr;
        WriteData = data;
        tick();
        RegWre    = 1'b0;
    endtask

    task automatic test_reset();
        write_reg(5'd1, 32'h0000_0011);
        write_reg(5'd2, 32'h0000_2222);
        write_reg(5'd3, 32'h3333_3333);
        write_reg(5'd31, 32'h8000_0001);
        #1;
        compared++;
        if (WrCount !== 16'd4) begin
            mismatched++;
            $display("[TB] FAIL reset_pre_count: got %0d expected 4", WrCount);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = i[4:0];
            ReadReg2 = 5'(31 - i);
            #1;
            compared++;
            if (ReadData1 !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL reset_rd1[%0d]: got %h expected 0", i, ReadData1);
            end
            compared++;
            if (ReadData2 !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL reset_rd2[%0d]: got %h expected 0", 31 - i, ReadData2);
            end
        end
        compared++;
        if (WrCount !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_count: got %0d expected 0", WrCount);
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 32'hDEAD_BEEF);
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd5;
        #1;
        compared++;
        if (ReadData1 !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("[TB] FAIL wr_rd1: got %h expected deadbeef", ReadData1);
        end
        compared++;
        if (ReadData2 !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("[TB] FAIL wr_rd2: got %h expected deadbeef", ReadData2);
        end
        compared++;
        if (WrCount !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL wr_count: got %0d expected 1", WrCount);
        end
    endtask

    task automatic test_zero_reg();
        RegWre    = 1'b1;
        WriteReg  = 5'd0;
        WriteData = 32'h1234_5678;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;
        #1;
        compared++;
        if (ReadData1 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL zero_during_wr: got %h expected 0", ReadData1);
        end
        tick();
        RegWre = 1'b0;
        #1;
        compared++;
        if (ReadData1 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL zero_after_wr: got %h expected 0", ReadData1);
        end
        compared++;
        if (WrCount !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL zero_count: got %0d expected 1", WrCount);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_same;
`ifdef REG_FILE_BYPASS_EN
        exp_same = 32'hA5A5_A5A5;
`else
        exp_same = 32'h0000_0001;
`endif
        write_reg(5'd7, 32'h0000_0001);
        RegWre    = 1'b1;
        WriteReg  = 5'd7;
        WriteData = 32'hA5A5_A5A5;
        ReadReg1  = 5'd7;
        ReadReg2  = 5'd7;
        #1;
        compared++;
        if (ReadData1 !== exp_same) begin
            mismatched++;
            $display("[TB] FAIL same_cycle_rd1: got %h expected %h", ReadData1, exp_same);
        end
        compared++;
        if (ReadData2 !== exp_same) begin
            mismatched++;
            $display("[TB] FAIL same_cycle_rd2: got %h expected %h", ReadData2, exp_same);
        end
        tick();
        RegWre = 1'b0;
        #1;
        compared++;
        if (ReadData1 !== 32'hA5A5_A5A5) begin
            mismatched++;
            $display("[TB] FAIL next_cycle_rd1: got %h expected a5a5a5a5", ReadData1);
        end
        // An unknown enable must leave reg 7 and the counter alone
        RegWre    = 1'bx;
        WriteReg  = 5'd7;
        WriteData = 32'h0;
        tick();
        RegWre = 1'b0;
        #1;
        compared++;
        if (ReadData2 !== 32'hA5A5_A5A5) begin
            mismatched++;
            $display("[TB] FAIL x_enable_data: got %h expected a5a5a5a5", ReadData2);
        end
        compared++;
        if (WrCount !== 16'd3) begin
            mismatched++;
            $display("[TB] FAIL x_enable_count: got %0d expected 3", WrCount);
        end
    endtask

    task automatic test_reset_priority();
        Reset     = 1'b1;
        RegWre    = 1'b1;
        WriteReg  = 5'd3;
        WriteData = 32'hFFFF_FFFF;
        tick();
        Reset    = 1'b0;
        RegWre   = 1'b0;
        ReadReg1 = 5'd3;
        ReadReg2 = 5'd7;
        #1;
        compared++;
        if (ReadData1 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL rst_prio_reg3: got %h expected 0", ReadData1);
        end
        compared++;
        if (ReadData2 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL rst_prio_reg7: got %h expected 0", ReadData2);
        end
        compared++;
        if (WrCount !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL rst_prio_count: got %0d expected 0", WrCount);
        end
        write_reg(5'd9, 32'h0000_0055);
        ReadReg1 = 5'd9;
        #1;
        compared++;
        if (ReadData1 !== 32'h0000_0055) begin
            mismatched++;
            $display("[TB] FAIL resume_data: got %h expected 00000055", ReadData1);
        end
        compared++;
        if (WrCount !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL resume_count: got %0d expected 1", WrCount);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd2;
`ifdef REG_FILE_BYPASS_EN
        exp_rd2 = 32'h0000_0022;
`else
        exp_rd2 = 32'h0000_0000;
`endif
        write_reg(5'd11, 32'h0000_0011);
        RegWre    = 1'b1;
        WriteReg  = 5'd12;
        WriteData = 32'h0000_0022;
        ReadReg1  = 5'd11;
        ReadReg2  = 5'd12;
        #1;
        compared++;
        if (ReadData1 !== 32'h0000_0011) begin
            mismatched++;
            $display("[TB] FAIL b2b_rd1: got %h expected 00000011", ReadData1);
        end
        compared++;
        if (ReadData2 !== exp_rd2) begin
            mismatched++;
            $display("[TB] FAIL b2b_rd2_same: got %h expected %h", ReadData2, exp_rd2);
        end
        tick();
        RegWre = 1'b0;
        #1;
        compared++;
        if (ReadData2 !== 32'h0000_0022) begin
            mismatched++;
            $display("[TB] FAIL b2b_rd2_next: got %h expected 00000022", ReadData2);
        end
        compared++;
        if (WrCount !== 16'd3) begin
            mismatched++;
            $display("[TB] FAIL b2b_count: got %0d expected 3", WrCount);
        end
    endtask

    task automatic test_wrap();
        // Counter is at 3 here; 65532 more writes bring it to 16'hFFFF
        RegWre   = 1'b1;
        WriteReg = 5'd10;
        for (int i = 0; i < 65532; i++) begin
            WriteData = 32'(i);
            tick();
        end
        RegWre = 1'b0;
        #1;
        compared++;
        if (WrCount !== 16'hFFFF) begin
            mismatched++;
            $display("[TB] FAIL wrap_max: got %h expected ffff", WrCount);
        end
        write_reg(5'd10, 32'hCAFE_F00D);
        ReadReg1 = 5'd10;
        ReadReg2 = 5'd9;
        #1;
        compared++;
        if (WrCount !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL wrap_zero: got %h expected 0000", WrCount);
        end
        compared++;
        if (ReadData1 !== 32'hCAFE_F00D) begin
            mismatched++;
            $display("[TB] FAIL wrap_reg10: got %h expected cafef00d", ReadData1);
        end
        compared++;
        if (ReadData2 !== 32'h0000_0055) begin
            mismatched++;
            $display("[TB] FAIL wrap_reg9: got %h expected 00000055", ReadData2);
        end
    endtask

    initial begin
        Reset     = 1'b1;
        RegWre    = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        ReadReg1  = '0;
        ReadReg2  = '0;
        tick();
        tick();
        Reset = 1'b0;
        $display("[TB] starting directed tests");
        test_reset();
        test_write_read();
        test_zero_reg();
        test_same_cycle();
        test_reset_priority();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
